// File: rtl/spike_event_queue.sv
// spike_event_queue: circular FIFO that timestamps incoming spike events with a
// local time counter and presents the oldest one to an event-driven processor.
// Entries are popped only on the consumer's acknowledge; drops, spurious acks
// and peak occupancy are tracked as statistics.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   in_addr/in_valid  - spike enqueue request; in_ready = queue not full
//   time_tick         - advance current_time by one (wraps silently)
//   flush             - discard all queued events, statistics retained
//   event_addr/time   - head entry (forced to 0 while empty)
//   event_valid       - head entry present
//   event_processed   - consumer acknowledge, pops the head
//   occupancy         - current entry count
//   high_water        - peak occupancy since reset
//   dropped_events    - saturating count of pushes rejected while full
//   spurious_acks     - saturating count of acks received while empty
//   current_time      - timestamp counter
module spike_event_queue #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned TIME_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       time_tick,
  input  logic                       flush,
  output logic [ADDR_W-1:0]          event_addr,
  output logic [TIME_W-1:0]          event_time,
  output logic                       event_valid,
  input  logic                       event_processed,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [$clog2(DEPTH):0]     high_water,
  output logic [15:0]                dropped_events,
  output logic [15:0]                spurious_acks,
  output logic [TIME_W-1:0]          current_time
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [TIME_W-1:0] r_mem_time [DEPTH];

  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_occ;
  logic [CNT_W-1:0]  r_high_water;
  logic [15:0]       r_dropped;
  logic [15:0]       r_spurious;
  logic [TIME_W-1:0] r_time;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_spurious;
  logic [CNT_W-1:0]  w_occ_next;

  // Status decode from registered count only; no pop look-ahead on in_ready.
  always_comb begin
    w_full     = (r_occ == CNT_W'(DEPTH));
    w_empty    = (r_occ == '0);
    w_push     = in_valid && !w_full;
    w_pop      = event_processed && !w_empty;
    w_drop     = in_valid && w_full;
    w_spurious = event_processed && w_empty;
    w_occ_next = r_occ + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  // Entry storage; contents are don't-care after reset or flush.
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_push) begin
      r_mem_addr[r_wr_ptr] <= in_addr;
      r_mem_time[r_wr_ptr] <= r_time;
    end
  end

  // Pointers, occupancy, statistics and time counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_occ        <= '0;
      r_high_water <= '0;
      r_dropped    <= '0;
      r_spurious   <= '0;
      r_time       <= '0;
    end else begin
      if (time_tick) begin
        r_time <= r_time + TIME_W'(1);
      end
      if (flush) begin
        // Flush-cycle push and ack are neither counted as drops nor spurious.
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_occ    <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        r_occ <= w_occ_next;
        if (w_occ_next > r_high_water) begin
          r_high_water <= w_occ_next;
        end
        if (w_drop && (r_dropped != 16'hFFFF)) begin
          r_dropped <= r_dropped + 16'd1;
        end
        if (w_spurious && (r_spurious != 16'hFFFF)) begin
          r_spurious <= r_spurious + 16'd1;
        end
      end
    end
  end

  // Head outputs read straight from registered state, zeroed while empty.
  assign in_ready       = !w_full;
  assign event_valid    = !w_empty;
  assign event_addr     = w_empty ? '0 : r_mem_addr[r_rd_ptr];
  assign event_time     = w_empty ? '0 : r_mem_time[r_rd_ptr];
  assign occupancy      = r_occ;
  assign high_water     = r_high_water;
  assign dropped_events = r_dropped;
  assign spurious_acks  = r_spurious;
  assign current_time   = r_time;

endmodule

// File: tb/tb_spike_event_queue.sv
// Directed testbench for spike_event_queue: a vector table for basic push/pop
// timing, then hand sequences for fill/drop, wrap, delayed ack, time wrap,
// flush and reset priority.
module tb_spike_event_queue;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned TIME_W = 8;
  localparam int unsigned CNT_W  = 5;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] in_addr;
  logic              in_valid;
  logic              in_ready;
  logic              time_tick;
  logic              flush;
  logic [ADDR_W-1:0] event_addr;
  logic [TIME_W-1:0] event_time;
  logic              event_valid;
  logic              event_processed;
  logic [CNT_W-1:0]  occupancy;
  logic [CNT_W-1:0]  high_water;
  logic [15:0]       dropped_events;
  logic [15:0]       spurious_acks;
  logic [TIME_W-1:0] current_time;

  int n_tests = 0;
  int n_fail  = 0;

  spike_event_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIME_W(TIME_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_addr         (in_addr),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .time_tick       (time_tick),
    .flush           (flush),
    .event_addr      (event_addr),
    .event_time      (event_time),
    .event_valid     (event_valid),
    .event_processed (event_processed),
    .occupancy       (occupancy),
    .high_water      (high_water),
    .dropped_events  (dropped_events),
    .spurious_acks   (spurious_acks),
    .current_time    (current_time)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [7:0]  addr;
    logic        valid;
    logic        tick;
    logic        flush;
    logic        ack;
    logic        exp_ready;
    logic        exp_ev_valid;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_time;
    logic [4:0]  exp_occ;
    logic [4:0]  exp_hw;
    logic [15:0] exp_drop;
    logic [15:0] exp_spur;
    logic [7:0]  exp_ct;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; return #1 after the rising edge.
  task automatic step(input logic r, input logic [7:0] a, input logic v,
                      input logic t, input logic f, input logic ack);
    @(negedge clk);
    rst             = r;
    in_addr         = a;
    in_valid        = v;
    time_tick       = t;
    flush           = f;
    event_processed = ack;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic [7:0] h_addr;
  logic [7:0] h_time;
  logic [4:0] occ_before;

  initial begin
    rst = 1'b0; in_addr = '0; in_valid = 1'b0; time_tick = 1'b0;
    flush = 1'b0; event_processed = 1'b0;

    // rst addr vld tick fl ack | rdy ev addr time occ hw drop spur ct
    vecs[0] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 5'd0, 5'd0, 16'd0, 16'd0, 8'd0};
    vecs[1] = '{1'b0, 8'h2B, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h2B, 8'h00, 5'd1, 5'd1, 16'd0, 16'd0, 8'd0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h2B, 8'h00, 5'd1, 5'd1, 16'd0, 16'd0, 8'd0};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h2B, 8'h00, 5'd1, 5'd1, 16'd0, 16'd0, 8'd0};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h2B, 8'h00, 5'd1, 5'd1, 16'd0, 16'd0, 8'd1};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 5'd0, 5'd1, 16'd0, 16'd0, 8'd1};
    vecs[6] = '{1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 8'h01, 5'd1, 5'd1, 16'd0, 16'd0, 8'd2};
    vecs[7] = '{1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 8'h02, 5'd1, 5'd1, 16'd0, 16'd0, 8'd2};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 5'd0, 5'd1, 16'd0, 16'd0, 8'd2};

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].addr, vecs[i].valid, vecs[i].tick, vecs[i].flush, vecs[i].ack);
      chk($sformatf("v%0d in_ready", i),     32'(in_ready),       32'(vecs[i].exp_ready));
      chk($sformatf("v%0d event_valid", i),  32'(event_valid),    32'(vecs[i].exp_ev_valid));
      chk($sformatf("v%0d event_addr", i),   32'(event_addr),     32'(vecs[i].exp_addr));
      chk($sformatf("v%0d event_time", i),   32'(event_time),     32'(vecs[i].exp_time));
      chk($sformatf("v%0d occupancy", i),    32'(occupancy),      32'(vecs[i].exp_occ));
      chk($sformatf("v%0d high_water", i),   32'(high_water),     32'(vecs[i].exp_hw));
      chk($sformatf("v%0d dropped", i),      32'(dropped_events), 32'(vecs[i].exp_drop));
      chk($sformatf("v%0d spurious", i),     32'(spurious_acks),  32'(vecs[i].exp_spur));
      chk($sformatf("v%0d current_time", i), 32'(current_time),   32'(vecs[i].exp_ct));
    end

    // Fill to full, drop two, drain in order.
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("fill in_ready", 32'(in_ready), 32'd0);
    chk("fill occupancy", 32'(occupancy), 32'd16);
    step(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("fill dropped", 32'(dropped_events), 32'd2);
    chk("fill high_water", 32'(high_water), 32'd16);
    chk("fill occ after drop", 32'(occupancy), 32'd16);
    // Drop offered while full is still dropped even with a same-cycle pop.
    step(1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("full push+pop dropped", 32'(dropped_events), 32'd3);
    chk("full push+pop occ", 32'(occupancy), 32'd15);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("drain head %0d", i), 32'(event_addr), 32'(i));
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("drain empty valid", 32'(event_valid), 32'd0);
    chk("drain spurious", 32'(spurious_acks), 32'd0);

    // Advance pointers to 14, then steady push+pop across the wrap.
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    q.delete();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0, 1'b0);
      q.push_back(8'(8'h40 + i));
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("wrap head %0d", k), 32'(event_addr), 32'(q[0]));
      step(1'b0, 8'(8'h43 + k), 1'b1, 1'b0, 1'b0, 1'b1);
      void'(q.pop_front());
      q.push_back(8'(8'h43 + k));
      chk($sformatf("wrap occ %0d", k), 32'(occupancy), 32'd3);
    end

    // Delayed ack: head held stable for 4 cycles, one pop per pulse.
    for (int r = 0; r < 2; r++) begin
      h_addr = event_addr;
      h_time = event_time;
      occ_before = occupancy;
      chk($sformatf("dly%0d latched", r), 32'(h_addr), 32'(q[0]));
      for (int c = 0; c < 4; c++) begin
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk($sformatf("dly%0d c%0d addr", r, c), 32'(event_addr), 32'(q[0]));
        chk($sformatf("dly%0d c%0d time", r, c), 32'(event_time), 32'd0);
        chk($sformatf("dly%0d c%0d valid", r, c), 32'(event_valid), 32'd1);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      void'(q.pop_front());
      chk($sformatf("dly%0d occ", r), 32'(occupancy), 32'(occ_before - 5'd1));
      chk($sformatf("dly%0d next head", r), 32'(event_addr), 32'(q[0]));
    end

    // Timestamp wrap at 256, then spurious ack.
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("twrap current_time", 32'(current_time), 32'd4);
    step(1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("twrap addr", 32'(event_addr), 32'h55);
    chk("twrap time", 32'(event_time), 32'd4);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("twrap popped", 32'(event_valid), 32'd0);
    chk("twrap no spurious", 32'(spurious_acks), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("spurious ack", 32'(spurious_acks), 32'd1);
    chk("spurious occ", 32'(occupancy), 32'd0);

    // Flush with same-cycle push, ack and tick.
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'(8'h60 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("pre-flush occ", 32'(occupancy), 32'd5);
    step(1'b0, 8'h99, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("flush occ", 32'(occupancy), 32'd0);
    chk("flush valid", 32'(event_valid), 32'd0);
    chk("flush addr", 32'(event_addr), 32'd0);
    chk("flush dropped", 32'(dropped_events), 32'd0);
    chk("flush spurious", 32'(spurious_acks), 32'd0);
    chk("flush high_water", 32'(high_water), 32'd5);
    chk("flush tick", 32'(current_time), 32'd1);
    step(1'b0, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post-flush addr", 32'(event_addr), 32'h77);
    chk("post-flush time", 32'(event_time), 32'd1);
    chk("post-flush occ", 32'(occupancy), 32'd1);

    // Reset beats flush/push; a late ack afterwards is spurious.
    step(1'b1, 8'h88, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst prio occ", 32'(occupancy), 32'd0);
    chk("rst prio time", 32'(current_time), 32'd0);
    chk("rst prio hw", 32'(high_water), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("late ack spurious", 32'(spurious_acks), 32'd1);
    chk("late ack valid", 32'(event_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
